// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the accumulation datapath.
// Holds the IEEE754 single-precision field widths, the zero constant, the
// sequencer state encoding and a sign-flip helper.
package fp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Negation of an IEEE754 value is a pure sign-bit flip.
    function automatic logic [FP_W-1:0] fp_neg(input logic [FP_W-1:0] x);
        return {~x[FP_W-1], x[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fp_accum_seq.sv
// Reduction sequencer: sums N_TERMS single-precision terms into one result by
// driving an external combinational FP adder one term per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, clear        begin a reduction (IDLE only) / synchronous abort
//   in_valid/in_ready   input handshake for in_data (term) and in_sub (subtract)
//   add_a/add_b/add_op  adder operands: accumulator, term, subtract select
//   add_sum             combinational adder result
//   out_valid/out_ready output handshake for out_data (the accumulator)
//   busy                high whenever the sequencer is not idle
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int unsigned N_TERMS = 9,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_op,
    input  logic [31:0] add_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP_W-1:0]   acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              accept;

    // clear outranks the input handshake, so a term presented alongside it
    // is neither counted nor folded into acc.
    assign accept = in_valid & in_ready_q & ~clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // First term bypasses the adder so its zero-operand path
                    // never influences the result.
                    if (cnt_q == '0) begin
                        acc_d = in_sub ? fp_neg(in_data) : in_data;
                    end else begin
                        acc_d = add_sum;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= FP_ZERO;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = acc_q;
    assign add_a     = acc_q;
    assign add_b     = in_data;
    assign add_op    = in_sub;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq with a behavioural single-precision
// adder standing in for the external combinational adder.
module tb_fp_accum_seq;

    localparam int unsigned N_TERMS = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_sub = 1'b0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_op;
    logic [31:0] add_sum;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fp_accum_seq #(.N_TERMS(N_TERMS), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_op   (add_op),
        .add_sum  (add_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    // Exact for the small power-of-two-friendly values used here.
    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic        s;
        int          e;
        real         a;
        logic [22:0] man;
        if (v == 0.0) return 32'h0000_0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        man = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), man};
    endfunction

    always_comb begin
        add_sum = r2f(f2r(add_a) + (add_op ? -f2r(add_b) : f2r(add_b)));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        tick();
        in_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] first_d;
        logic        first_s;
        logic [31:0] rest_d;
        logic        rest_s;
        logic [31:0] exp_first;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{"ones",   32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0,
                    32'h3F80_0000, 32'h4110_0000};
        vecs[1] = '{"cancel", 32'h4000_0000, 1'b0, 32'h3E80_0000, 1'b1,
                    32'h4000_0000, 32'h0000_0000};
        vecs[2] = '{"negfst", 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0,
                    32'hBF80_0000, 32'h40E0_0000};

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Table-driven back-to-back reductions with out_ready held high.
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            do_start();
            check({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
            check({vecs[v].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            for (int i = 0; i < N_TERMS; i++) begin
                in_data = (i == 0) ? vecs[v].first_d : vecs[v].rest_d;
                in_sub  = (i == 0) ? vecs[v].first_s : vecs[v].rest_s;
                tick();
                if (i == 0) check({vecs[v].name, "_first"}, add_a, vecs[v].exp_first);
            end
            in_valid = 1'b0;
            check({vecs[v].name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
            check({vecs[v].name, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({vecs[v].name, "_sum"}, out_data, vecs[v].exp_sum);
            tick();
            check({vecs[v].name, "_busy_after"}, {31'd0, busy}, 32'd0);
            check({vecs[v].name, "_ov_after"}, {31'd0, out_valid}, 32'd0);
        end

        // Input gap after term 4, then output stall of 5 cycles.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < N_TERMS; i++) begin
            send(32'h3F80_0000, 1'b0);
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("gap_acc_hold", add_a, 32'h4080_0000);
                    check("gap_in_ready", {31'd0, in_ready}, 32'd1);
                end
            end
        end
        for (int s = 0; s < 5; s++) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_data", out_data, 32'h4110_0000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_release_busy", {31'd0, busy}, 32'd0);

        // clear together with a valid term after five terms.
        do_start();
        for (int i = 0; i < 5; i++) send(32'h3F80_0000, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", {31'd0, busy}, 32'd0);
        check("clear_in_ready", {31'd0, in_ready}, 32'd0);
        check("clear_acc_kept", out_data, 32'h40A0_0000);
        do_start();
        for (int i = 0; i < N_TERMS; i++) send(32'h3F80_0000, 1'b0);
        check("after_clear_valid", {31'd0, out_valid}, 32'd1);
        check("after_clear_sum", out_data, 32'h4110_0000);
        tick();

        // Asynchronous reset mid-reduction, applied between edges.
        do_start();
        for (int i = 0; i < 3; i++) send(32'h3F80_0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'h0);
        check("arst_add_a", add_a, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();

        // start while DONE with the output stalled is ignored.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < N_TERMS; i++) send(32'h3F80_0000, 1'b0);
        do_start();
        check("done_start_valid", {31'd0, out_valid}, 32'd1);
        check("done_start_busy", {31'd0, busy}, 32'd1);
        check("done_start_in_ready", {31'd0, in_ready}, 32'd0);
        check("done_start_data", out_data, 32'h4110_0000);
        out_ready = 1'b1;
        tick();
        check("done_release_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Sequencer that reduces a stream of N_TERMS single-precision IEEE754 values into one sum by driving the team's combinational floating-point adder one term per cycle. It holds a 32-bit accumulator register and a term counter, and uses valid/ready handshakes on both its input and output. It sits between the convolution window buffer and the result writer, and produces one window sum, for example a 3x3 kernel, per transaction.

## Interface
Parameters:
- N_TERMS, 9: terms per reduction. Legal range is 2..255.
- CNT_W, 8: counter width. Must satisfy 2^CNT_W > N_TERMS.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a reduction. Honoured only in IDLE.
- clear, input, 1: synchronous abort. Returns the block to IDLE from any state.
- in_valid, input, 1: in_data and in_sub are valid.
- in_ready, output, 1: the block accepts a term this cycle.
- in_data, input, 32: IEEE754 term.
- in_sub, input, 1: 1 means the term is subtracted rather than added.
- add_a, output, 32: adder operand A. Always equals acc.
- add_b, output, 32: adder operand B. Always equals in_data.
- add_op, output, 1: adder op select. Always equals in_sub.
- add_sum, input, 32: combinational result from the adder.
- out_valid, output, 1: out_data holds a finished sum.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, 32: final sum. Always equals acc.
- busy, output, 1: high whenever the state is not IDLE.

## Operation
States:
- IDLE: in_ready=0, out_valid=0.
  - start=1 → ACCUM. cnt is set to 0.
- ACCUM: in_ready=1.
  - On an accepted term (in_valid & in_ready) with cnt==0: acc loads the term directly, without using the adder. The loaded value is in_sub ? {~in_data[31], in_data[30:0]} : in_data. Loading directly avoids the adder's zero-operand path.
  - On an accepted term with cnt>0: acc loads add_sum.
  - Every accepted term increments cnt.
  - When the accepted term has cnt==N_TERMS-1, the next state is DONE.
- DONE: out_valid=1, in_ready=0.
  - out_valid & out_ready → IDLE.
  - acc is held until the next reduction's first term is loaded.

Rules and boundary conditions:
- clear=1 forces IDLE and cnt=0 in the next cycle, from any state. It has priority over start, over an input handshake and over an output handshake in the same cycle. acc is not modified by clear.
- start is ignored while busy.
- start and in_valid may both be high in IDLE. No term is accepted in that cycle, because in_ready=0.
- in_valid=0 while in ACCUM holds the state, cnt and acc. Gaps between terms are unlimited.
- No rounding or normalisation is performed in this block. The arithmetic result is exactly what the adder returns.
- The block does not check for NaN or Inf.
- Reset (rst_n=0) values: state=IDLE, cnt=0, acc=32'h0000_0000, in_ready=0, out_valid=0, busy=0, out_data=0, add_a=0.
- A reset in the middle of a reduction discards the partial sum immediately, asynchronously.

## Timing
- The adder is combinational. The path add_a/add_b → add_sum → acc must close within one clk period. This is the critical path.
- Throughput is one term per cycle while in_valid stays high.
- Latency, with continuous input and no backpressure:
  - start is seen at edge 0.
  - Terms are accepted at edges 1..N_TERMS.
  - out_valid rises after edge N_TERMS.
  - At the earliest, the result is consumed at edge N_TERMS+1.
  - The earliest next start is seen at edge N_TERMS+2, with the block in IDLE.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- All outputs are registered, or are direct copies of registers or inputs: add_b and add_op mirror the inputs.

## Structure
- Shared package fp_pkg holds:
  - FP_W=32, EXP_W=8, MAN_W=23.
  - FP_ZERO=32'h0000_0000.
  - The state encoding typedef: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - The function fp_neg(x), which flips bit 31.
- The adder stays outside this block, so one instance can later be time-shared through an arbiter.
- A wrapper, fp_accum_unit, is the natural single sub-module pairing. It instantiates fp_accum_seq together with the existing combinational adder (out, A, B, op).

## Test plan
- Reset, nine terms of 1.0 (0x3F800000, in_sub=0), back-to-back, out_ready=1 → out_valid after 9 accepts, out_data=0x41100000 (9.0), busy falls one cycle after the handshake.
- First term 2.0 (0x40000000), then eight terms of 0.25 (0x3E800000) with in_sub=1 → out_data=0x00000000 (the exact cancellation on the last step returns zero).
- First term 1.0 with in_sub=1, then eight terms of +1.0 → first load gives acc=0xBF800000, and the final out_data=0x40E00000 (7.0).
- Nine terms of 1.0 with in_valid deasserted for 3 cycles after term 4, and out_ready held low 5 cycles after out_valid rises → result is still 0x41100000, in_ready=0 in DONE, out_data stable throughout the stall.
- clear asserted after term 5, in the same cycle as in_valid=1 → IDLE next cycle, term not counted, cnt=0. A following full 9-term run of 1.0 yields 0x41100000.
- rst_n pulsed low asynchronously in the middle of ACCUM (between edges) → all outputs at reset values immediately, acc=0. start while DONE with out_ready=0 → ignored, state unchanged.
